risc_run_ctrl: RTL

RISC_RUN_CTRL -- requirements
Module: risc_run_ctrl

---
 rtl/risc_run_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/risc_run_ctrl.sv
// Run/step/stop controller for a RISC core: gates the pipeline enable,
// counts enabled cycles and records why execution last stopped.
module risc_run_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [15:0]       step_count,
    output logic              cmd_ready,
    input  logic              bp_en,
    input  logic [DATA_W-1:0] bp_pc,
    input  logic [DATA_W-1:0] pc_if,
    input  logic              cpu_halt,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic [2:0]        stop_cause,
    output logic [DATA_W-1:0] cycle_cnt,
    output logic              done_pulse
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [2:0] C_NONE = 3'b000;
    localparam logic [2:0] C_STEP = 3'b001;
    localparam logic [2:0] C_BP   = 3'b010;
    localparam logic [2:0] C_HALT = 3'b011;
    localparam logic [2:0] C_STOP = 3'b100;

    state_t      st;
    logic [15:0] step_left;
    logic        bp_mask;
    logic        cmd_acc;
    logic        bp_hit;
    logic        halt_lock;
    logic        clr_acc;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign cmd_ready = 1'b1;
    assign state     = st;
    assign cmd_acc   = cmd_valid & cmd_ready;
    // Mask covers only the first enabled cycle after resuming from a breakpoint.
    assign bp_hit    = bp_en & cpu_en & ~bp_mask & (pc_if == bp_pc);
    assign halt_lock = (st == S_DONE) && (stop_cause == C_HALT);
    assign clr_acc   = cmd_acc && (cmd_op == OP_CLEAR) && (st == S_IDLE || st == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= S_IDLE;
            cpu_en     <= 1'b0;
            stop_cause <= C_NONE;
            cycle_cnt  <= '0;
            done_pulse <= 1'b0;
            step_left  <= '0;
            bp_mask    <= 1'b0;
        end else begin
            done_pulse <= 1'b0;

            if (clr_acc)
                cycle_cnt <= '0;
            else if (cpu_en)
                cycle_cnt <= sat_inc(cycle_cnt);

            case (st)
                S_IDLE, S_DONE: begin
                    if (cmd_acc) begin
                        case (cmd_op)
                            OP_RUN: begin
                                if (!halt_lock) begin
                                    st         <= S_RUN;
                                    cpu_en     <= 1'b1;
                                    bp_mask    <= (stop_cause == C_BP);
                                    stop_cause <= C_NONE;
                                end
                            end
                            OP_STEP: begin
                                if (!halt_lock && step_count != 16'd0) begin
                                    st         <= S_STEP;
                                    cpu_en     <= 1'b1;
                                    step_left  <= step_count;
                                    bp_mask    <= (stop_cause == C_BP);
                                    stop_cause <= C_NONE;
                                end
                            end
                            OP_CLEAR: begin
                                st         <= S_IDLE;
                                stop_cause <= C_NONE;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN, S_STEP: begin
                    bp_mask <= 1'b0;
                    if (st == S_STEP)
                        step_left <= step_left - 16'd1;
                    // Exit priority: halt, breakpoint, stop command, step exhausted.
                    if (cpu_halt || bp_hit || (cmd_acc && cmd_op == OP_STOP)
                        || (st == S_STEP && step_left == 16'd1)) begin
                        st         <= S_DONE;
                        cpu_en     <= 1'b0;
                        done_pulse <= 1'b1;
                        if (cpu_halt)
                            stop_cause <= C_HALT;
                        else if (bp_hit)
                            stop_cause <= C_BP;
                        else if (cmd_acc && cmd_op == OP_STOP)
                            stop_cause <= C_STOP;
                        else
                            stop_cause <= C_STEP;
                    end
                end
                default: begin
                    st     <= S_IDLE;
                    cpu_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
